// File: rtl/riscv32ima_issue_ctrl.sv
// Decode->execute issue gate with a per-GPR pending scoreboard; blocks on RAW/WAW/full/redirect.
// Zero-latency combinational handshake; scoreboard and counters update on the next rising edge.
module riscv32ima_issue_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MAX_INFLIGHT    = 4,
  parameter int CNT_WIDTH       = 3,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]  in_src0_addr,
  input  logic                       in_src0_used,
  input  logic [REG_ADDR_WIDTH-1:0]  in_src1_addr,
  input  logic                       in_src1_used,
  input  logic [REG_ADDR_WIDTH-1:0]  in_dst_addr,
  input  logic                       in_dst_wen,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0]  wback_reg_addr,
  input  logic                       wback_pc_wen,
  output logic [31:0]                pending,
  output logic [CNT_WIDTH-1:0]       inflight_cnt,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
  output logic                       sb_err
);

  logic [31:0]                r_pending;
  logic [CNT_WIDTH-1:0]       r_inflight;
  logic [STALL_CNT_WIDTH-1:0] r_stall;
  logic                       r_sb_err;

  logic        w_raw0, w_raw1, w_waw, w_full, w_block;
  logic        w_dst_nz, w_wb_nz, w_issue, w_set, w_rel, w_err, w_stall;
  logic [31:0] w_set_mask, w_clr_mask;

  assign w_dst_nz = in_dst_wen && (in_dst_addr != '0);
  assign w_wb_nz  = wback_reg_wen && (wback_reg_addr != '0);

  // Hazards look only at registered pending state: a releasing register still blocks this cycle.
  assign w_raw0  = in_src0_used && (in_src0_addr != '0) && r_pending[in_src0_addr];
  assign w_raw1  = in_src1_used && (in_src1_addr != '0) && r_pending[in_src1_addr];
  assign w_waw   = w_dst_nz && r_pending[in_dst_addr];
  assign w_full  = (r_inflight == CNT_WIDTH'(MAX_INFLIGHT)) && w_dst_nz;
  assign w_block = w_raw0 || w_raw1 || w_waw || w_full || wback_pc_wen;

  assign out_valid = in_valid && !w_block;
  assign in_ready  = out_ready && !w_block;

  assign w_issue = in_valid && in_ready;
  assign w_set   = w_issue && w_dst_nz;
  assign w_rel   = w_wb_nz && r_pending[wback_reg_addr];
  assign w_err   = w_wb_nz && !r_pending[wback_reg_addr];
  assign w_stall = in_valid && !in_ready;

  assign w_set_mask = w_set ? (32'd1 << in_dst_addr) : 32'd0;
  assign w_clr_mask = w_rel ? (32'd1 << wback_reg_addr) : 32'd0;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_pending  <= '0;
      r_inflight <= '0;
      r_stall    <= '0;
      r_sb_err   <= 1'b0;
    end else begin
      r_pending <= ((r_pending | w_set_mask) & ~w_clr_mask) & ~32'd1;
      if (w_set && !w_rel) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_set && w_rel) begin
        r_inflight <= r_inflight - 1'b1;
      end
      if (w_stall && (r_stall != {STALL_CNT_WIDTH{1'b1}})) begin
        r_stall <= r_stall + 1'b1;
      end
      if (w_err) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign pending      = r_pending;
  assign inflight_cnt = r_inflight;
  assign stall_cnt    = r_stall;
  assign sb_err       = r_sb_err;

endmodule

// File: tb/tb_riscv32ima_issue_ctrl.sv
// Directed bench for riscv32ima_issue_ctrl: inputs change on the falling edge, outputs sampled off-edge.
module tb_riscv32ima_issue_ctrl;

  localparam int AW = 5;
  localparam int CW = 3;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_src0_addr, in_src1_addr, in_dst_addr;
  logic          in_src0_used, in_src1_used, in_dst_wen;
  logic          out_valid, out_ready;
  logic          wback_reg_wen, wback_pc_wen;
  logic [AW-1:0] wback_reg_addr;
  logic [31:0]   pending;
  logic [CW-1:0] inflight_cnt;
  logic [SW-1:0] stall_cnt;
  logic          sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv32ima_issue_ctrl #(
    .REG_ADDR_WIDTH(AW), .MAX_INFLIGHT(4), .CNT_WIDTH(CW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src0_addr(in_src0_addr), .in_src0_used(in_src0_used),
    .in_src1_addr(in_src1_addr), .in_src1_used(in_src1_used),
    .in_dst_addr(in_dst_addr), .in_dst_wen(in_dst_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .wback_reg_wen(wback_reg_wen), .wback_reg_addr(wback_reg_addr),
    .wback_pc_wen(wback_pc_wen),
    .pending(pending), .inflight_cnt(inflight_cnt),
    .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  task automatic idle();
    in_valid = 0; in_src0_addr = 0; in_src0_used = 0; in_src1_addr = 0; in_src1_used = 0;
    in_dst_addr = 0; in_dst_wen = 0; out_ready = 1;
    wback_reg_wen = 0; wback_reg_addr = 0; wback_pc_wen = 0;
  endtask

  task automatic instr(input logic [AW-1:0] s0, input logic u0, input logic [AW-1:0] s1,
                       input logic u1, input logic [AW-1:0] d, input logic w);
    in_valid = 1; in_src0_addr = s0; in_src0_used = u0; in_src1_addr = s1; in_src1_used = u1;
    in_dst_addr = d; in_dst_wen = w;
  endtask

  task automatic wback(input logic en, input logic [AW-1:0] a);
    wback_reg_wen = en; wback_reg_addr = a;
  endtask

  task automatic do_reset();
    idle();
    nrst = 1;
    @(negedge clk);
    @(negedge clk);
    nrst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %0h want 0", pending); end
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight_cnt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %0b want 0", sb_err); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    instr(0, 0, 0, 0, 5, 1);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL raw_addi_issue got rdy=%0b vld=%0b want 1/1", in_ready, out_valid); end
    @(negedge clk);
    checks++; if (pending !== 32'h20) begin errors++; $display("FAIL raw_pending5 got %0h want 20", pending); end
    checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL raw_inflight1 got %0d want 1", inflight_cnt); end
    instr(5, 1, 0, 1, 6, 1);
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL raw_blocked got rdy=%0b vld=%0b want 0/0", in_ready, out_valid); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL raw_stall1 got %0d want 1", stall_cnt); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL raw_stall2 got %0d want 2", stall_cnt); end
    wback(1, 5);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got %0b want 0", in_ready); end
    @(negedge clk);
    wback(0, 0);
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL raw_stall3 got %0d want 3", stall_cnt); end
    checks++; if (inflight_cnt !== 3'd0 || pending !== 32'd0) begin errors++; $display("FAIL raw_released got cnt=%0d pend=%0h want 0/0", inflight_cnt, pending); end
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL raw_dep_issue got rdy=%0b vld=%0b want 1/1", in_ready, out_valid); end
    @(negedge clk);
    idle();
    checks++; if (pending !== 32'h40 || inflight_cnt !== 3'd1) begin errors++; $display("FAIL raw_x6_pending got pend=%0h cnt=%0d want 40/1", pending, inflight_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      instr(0, 0, 0, 0, AW'(i), 1);
      @(negedge clk);
    end
    checks++; if (inflight_cnt !== 3'd4 || pending !== 32'h1E) begin errors++; $display("FAIL full_four got cnt=%0d pend=%0h want 4/1e", inflight_cnt, pending); end
    instr(0, 0, 0, 0, 7, 1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_x7_blocked got %0b want 0", in_ready); end
    @(negedge clk);
    instr(8, 1, 9, 1, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL full_store_issue got rdy=%0b vld=%0b want 1/1", in_ready, out_valid); end
    @(negedge clk);
    instr(0, 0, 0, 0, 7, 1);
    wback(1, 2);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_release_cycle got %0b want 0", in_ready); end
    @(negedge clk);
    wback(0, 0);
    checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL full_after_wb got %0d want 3", inflight_cnt); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_x7_issue got %0b want 1", in_ready); end
    @(negedge clk);
    idle();
    checks++; if (inflight_cnt !== 3'd4 || pending !== 32'h9A) begin errors++; $display("FAIL full_final got cnt=%0d pend=%0h want 4/9a", inflight_cnt, pending); end
  endtask

  task automatic test_waw();
    do_reset();
    instr(0, 0, 0, 0, 10, 1);
    @(negedge clk);
    instr(0, 0, 0, 0, 10, 1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_blocked got %0b want 0", in_ready); end
    @(negedge clk);
    wback(1, 10);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_release_cycle got %0b want 0", in_ready); end
    @(negedge clk);
    wback(0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_issue got %0b want 1", in_ready); end
    @(negedge clk);
    idle();
    checks++; if (pending !== 32'h400 || inflight_cnt !== 3'd1) begin errors++; $display("FAIL waw_state got pend=%0h cnt=%0d want 400/1", pending, inflight_cnt); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL waw_stall got %0d want 2", stall_cnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    instr(0, 0, 0, 0, 12, 1);
    @(negedge clk);
    instr(0, 0, 0, 0, 13, 1);
    @(negedge clk);
    instr(0, 0, 0, 0, 11, 1);
    wback(1, 12);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_issue got %0b want 1", in_ready); end
    @(negedge clk);
    idle();
    checks++; if (pending !== 32'h2800 || inflight_cnt !== 3'd2) begin errors++; $display("FAIL same_state got pend=%0h cnt=%0d want 2800/2", pending, inflight_cnt); end
  endtask

  task automatic test_x0_err();
    do_reset();
    instr(0, 1, 0, 1, 0, 1);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL x0_issue got rdy=%0b vld=%0b want 1/1", in_ready, out_valid); end
    @(negedge clk);
    idle();
    checks++; if (pending !== 32'd0 || inflight_cnt !== 3'd0) begin errors++; $display("FAIL x0_state got pend=%0h cnt=%0d want 0/0", pending, inflight_cnt); end
    wback(1, 0);
    @(negedge clk);
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL x0_wb_err got %0b want 0", sb_err); end
    wback(1, 20);
    @(negedge clk);
    wback(0, 0);
    checks++; if (sb_err !== 1'b1 || pending !== 32'd0 || inflight_cnt !== 3'd0) begin errors++; $display("FAIL x20_err got err=%0b pend=%0h cnt=%0d want 1/0/0", sb_err, pending, inflight_cnt); end
    @(negedge clk);
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", sb_err); end
  endtask

  task automatic test_redirect_reset();
    do_reset();
    instr(0, 0, 0, 0, 3, 1);
    @(negedge clk);
    instr(0, 0, 0, 0, 9, 1);
    wback_pc_wen = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL redirect got vld=%0b rdy=%0b want 0/0", out_valid, in_ready); end
    @(negedge clk);
    wback_pc_wen = 0;
    out_ready = 0;
    checks++; if (stall_cnt !== 32'd1 || pending !== 32'h8) begin errors++; $display("FAIL redirect_state got stall=%0d pend=%0h want 1/8", stall_cnt, pending); end
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL backpressure got vld=%0b rdy=%0b want 1/0", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd2 || inflight_cnt !== 3'd1) begin errors++; $display("FAIL bp_stall got stall=%0d cnt=%0d want 2/1", stall_cnt, inflight_cnt); end
    idle();
    nrst = 1;
    @(negedge clk);
    nrst = 0;
    checks++; if (pending !== 32'd0 || inflight_cnt !== 3'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL midreset got pend=%0h cnt=%0d stall=%0d want 0/0/0", pending, inflight_cnt, stall_cnt); end
    wback(1, 3);
    @(negedge clk);
    wback(0, 0);
    checks++; if (sb_err !== 1'b1 || inflight_cnt !== 3'd0) begin errors++; $display("FAIL stale_wb got err=%0b cnt=%0d want 1/0", sb_err, inflight_cnt); end
  endtask

  initial begin
    idle();
    nrst = 1;
    @(negedge clk);
    test_reset();
    test_raw();
    test_full();
    test_waw();
    test_same_cycle();
    test_x0_err();
    test_redirect_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
